// File: rtl/mem_interface_if.sv
// Signal bundle between the CPU-side controller/RAM environment and the mem_interface unit.
// slave: the mem_interface unit itself; master: everything around it (control, bus, memory_ram).
// err is present only when MEM_RANGE_CHECK_EN is defined.
interface mem_interface_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] bus_in;
    logic                  mar_in;
    logic                  mdr_in;
    logic                  mem_rd;
    logic                  mem_wr;
    logic [DATA_WIDTH-1:0] mdr_out;
    logic [ADDR_WIDTH-1:0] mar_out;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  ram_read;
    logic                  ram_write;
    logic [DATA_WIDTH-1:0] ram_rdata;
`ifdef MEM_RANGE_CHECK_EN
    logic                  err;
`endif

    modport slave (
        input  bus_in, mar_in, mdr_in, mem_rd, mem_wr, ram_rdata,
        output mdr_out, mar_out, busy, done, ram_addr, ram_wdata, ram_read, ram_write
`ifdef MEM_RANGE_CHECK_EN
        , output err
`endif
    );

    modport master (
        output bus_in, mar_in, mdr_in, mem_rd, mem_wr, ram_rdata,
        input  mdr_out, mar_out, busy, done, ram_addr, ram_wdata, ram_read, ram_write
`ifdef MEM_RANGE_CHECK_EN
        , input err
`endif
    );
endinterface

// File: rtl/mem_interface.sv
// mem_interface: holds MAR/MDR, sequences memory_ram read/write strobes and captures read data.
// Latency: read 3+WAIT_STATES, write 2+WAIT_STATES cycles from the request edge to the done pulse.
// Backpressure: none; requests and MAR/MDR loads arriving while busy or in the done cycle are dropped.
// Optional MEM_RANGE_CHECK_EN: a MAR load with upper bus bits set makes the next request finish at once with err.
module mem_interface #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic           clk,
    input  logic           clr_n,
    mem_interface_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_RD_STROBE, S_WR_STROBE, S_WAIT, S_CAPTURE, S_DONE
    } state_t;

    localparam bit         HAS_WAIT  = (WAIT_STATES > 0);
    // Last count value of the wait phase; unused when there are no wait states.
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] mar;
    logic [DATA_WIDTH-1:0] mdr;
    logic [3:0]            wait_cnt;
    logic                  dir_rd;
    logic                  busy_q;
    logic                  done_q;
    logic                  ram_read_q;
    logic                  ram_write_q;
    logic                  req;
    logic                  req_oob;

    assign req = bus.mem_rd | bus.mem_wr;

`ifdef MEM_RANGE_CHECK_EN
    logic mar_hi;
    logic err_q;

    // Judge the MAR the request will actually use, including a load in the same cycle.
    assign req_oob = bus.mar_in ? (|bus.bus_in[DATA_WIDTH-1:ADDR_WIDTH]) : mar_hi;

    // Remember whether the last MAR load overflowed; err marks the done cycle of a rejected request.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mar_hi <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (state == S_IDLE && bus.mar_in)
                mar_hi <= |bus.bus_in[DATA_WIDTH-1:ADDR_WIDTH];
            err_q <= (state == S_IDLE) && req && req_oob;
        end
    end

    assign bus.err = err_q;
`else
    assign req_oob = 1'b0;
`endif

    // Next-state selection; read wins over a simultaneous write.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req)
                    state_nxt = req_oob ? S_DONE : (bus.mem_rd ? S_RD_STROBE : S_WR_STROBE);
            end
            S_RD_STROBE: state_nxt = HAS_WAIT ? S_WAIT : S_CAPTURE;
            S_WR_STROBE: state_nxt = HAS_WAIT ? S_WAIT : S_DONE;
            S_WAIT: begin
                if (wait_cnt == WAIT_LAST)
                    state_nxt = dir_rd ? S_CAPTURE : S_DONE;
            end
            S_CAPTURE:   state_nxt = S_DONE;
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // FSM state plus outputs registered from the state being entered.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state       <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ram_read_q  <= 1'b0;
            ram_write_q <= 1'b0;
            wait_cnt    <= 4'd0;
            dir_rd      <= 1'b0;
        end else begin
            state       <= state_nxt;
            busy_q      <= (state_nxt == S_RD_STROBE) || (state_nxt == S_WR_STROBE) ||
                           (state_nxt == S_WAIT)      || (state_nxt == S_CAPTURE);
            done_q      <= (state_nxt == S_DONE);
            ram_read_q  <= (state_nxt == S_RD_STROBE);
            ram_write_q <= (state_nxt == S_WR_STROBE);
            wait_cnt    <= (state == S_WAIT) ? wait_cnt + 4'd1 : 4'd0;
            if (state == S_IDLE && req)
                dir_rd <= bus.mem_rd;
        end
    end

    // MAR/MDR only move while idle, so RAM inputs hold steady for the whole access.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mar <= '0;
            mdr <= '0;
        end else if (state == S_IDLE) begin
            if (bus.mar_in)
                mar <= bus.bus_in[ADDR_WIDTH-1:0];
            if (bus.mdr_in)
                mdr <= bus.bus_in;
        end else if (state == S_CAPTURE) begin
            mdr <= bus.ram_rdata;
        end
    end

    assign bus.mdr_out   = mdr;
    assign bus.mar_out   = mar;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.ram_addr  = mar;
    assign bus.ram_wdata = mdr;
    assign bus.ram_read  = ram_read_q;
    assign bus.ram_write = ram_write_q;
endmodule

// File: tb/tb_mem_interface.sv
// Bench for mem_interface: two instances (0 and 2 wait states) with behavioural RAMs.
// Stimulus pushes expected strobes/completions into queues; a negedge monitor pops and compares.
// Reset outputs are checked by the monitor on every cycle that clr_n is low.
module tb_mem_interface;
    localparam int AW  = 9;
    localparam int DW  = 32;
    localparam int WS0 = 0;
    localparam int WS1 = 2;

    typedef struct {
        int            inst;
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          wr;
    } strobe_t;

    typedef struct {
        int            inst;
        int            cyc;
        logic [AW-1:0] mar;
        logic [DW-1:0] mdr;
        logic          err;
    } done_t;

    logic clk   = 1'b0;
    logic clr_n = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;
    int   tmo    = 0;
    logic stim_done = 1'b0;

    strobe_t sq[$];
    done_t   dq[$];

    logic [DW-1:0] d_bus [2];
    logic          d_mar [2];
    logic          d_mdr [2];
    logic          d_rd  [2];
    logic          d_wr  [2];
    logic [DW-1:0] rdata [2];

    logic [DW-1:0] o_mdr   [2];
    logic [AW-1:0] o_mar   [2];
    logic          o_busy  [2];
    logic          o_done  [2];
    logic [AW-1:0] o_addr  [2];
    logic [DW-1:0] o_wdata [2];
    logic          o_rd    [2];
    logic          o_wr    [2];
    logic          o_err   [2];

    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_a  = '0;
    logic [DW-1:0] pre_d  = '0;
    logic [DW-1:0] ram [2][512];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mem_interface_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    mem_interface_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

    mem_interface #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(WS0)) dut0 (
        .clk(clk), .clr_n(clr_n), .bus(bus0));
    mem_interface #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(WS1)) dut1 (
        .clk(clk), .clr_n(clr_n), .bus(bus1));

    assign bus0.bus_in = d_bus[0];  assign bus1.bus_in = d_bus[1];
    assign bus0.mar_in = d_mar[0];  assign bus1.mar_in = d_mar[1];
    assign bus0.mdr_in = d_mdr[0];  assign bus1.mdr_in = d_mdr[1];
    assign bus0.mem_rd = d_rd[0];   assign bus1.mem_rd = d_rd[1];
    assign bus0.mem_wr = d_wr[0];   assign bus1.mem_wr = d_wr[1];
    assign bus0.ram_rdata = rdata[0];
    assign bus1.ram_rdata = rdata[1];

    assign o_mdr[0]   = bus0.mdr_out;   assign o_mdr[1]   = bus1.mdr_out;
    assign o_mar[0]   = bus0.mar_out;   assign o_mar[1]   = bus1.mar_out;
    assign o_busy[0]  = bus0.busy;      assign o_busy[1]  = bus1.busy;
    assign o_done[0]  = bus0.done;      assign o_done[1]  = bus1.done;
    assign o_addr[0]  = bus0.ram_addr;  assign o_addr[1]  = bus1.ram_addr;
    assign o_wdata[0] = bus0.ram_wdata; assign o_wdata[1] = bus1.ram_wdata;
    assign o_rd[0]    = bus0.ram_read;  assign o_rd[1]    = bus1.ram_read;
    assign o_wr[0]    = bus0.ram_write; assign o_wr[1]    = bus1.ram_write;
`ifdef MEM_RANGE_CHECK_EN
    assign o_err[0]   = bus0.err;       assign o_err[1]   = bus1.err;
`else
    assign o_err[0]   = 1'b0;           assign o_err[1]   = 1'b0;
`endif

    // Behavioural memory_ram per instance: write on strobe, read data valid the cycle after.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (pre_we) ram[k][pre_a] <= pre_d;
            if (o_wr[k]) ram[k][o_addr[k]] <= o_wdata[k];
            if (o_rd[k]) rdata[k] <= ram[k][o_addr[k]];
        end
    end

    function automatic int ws(int i);
        return (i == 0) ? WS0 : WS1;
    endfunction

    function automatic bit sel(int k, int i);
        return (k == 2) || (k == i);
    endfunction

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(string name, int k, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d got=0x%0h want=0x%0h (cyc %0d)", name, k, act, exp, cyc);
        end
    endtask

    task automatic unexpected(string name, int k);
        checks++;
        errors++;
        $display("FAIL %s inst=%0d got=asserted want=idle (cyc %0d)", name, k, cyc);
    endtask

    task automatic mon_strobe(int k);
        int idx;
        strobe_t e;
        idx = -1;
        for (int j = 0; j < sq.size(); j++)
            if (idx < 0 && sq[j].inst == k) idx = j;
        if (idx < 0) begin
            unexpected("ram_strobe", k);
        end else begin
            e = sq[idx];
            sq.delete(idx);
            chk("strobe_cycle", k, cyc, e.cyc);
            chk("strobe_kind", k, {o_rd[k], o_wr[k]}, e.wr ? 2'b01 : 2'b10);
            chk("strobe_addr", k, o_addr[k], e.addr);
            chk("strobe_busy", k, o_busy[k], 1);
            if (e.wr) chk("strobe_wdata", k, o_wdata[k], e.data);
        end
    endtask

    task automatic mon_done(int k);
        int idx;
        done_t e;
        idx = -1;
        for (int j = 0; j < dq.size(); j++)
            if (idx < 0 && dq[j].inst == k) idx = j;
        if (idx < 0) begin
            unexpected("done", k);
        end else begin
            e = dq[idx];
            dq.delete(idx);
            chk("done_cycle", k, cyc, e.cyc);
            chk("done_mdr", k, o_mdr[k], e.mdr);
            chk("done_mar", k, o_mar[k], e.mar);
            chk("done_err", k, o_err[k], e.err);
            chk("done_busy", k, o_busy[k], 0);
        end
    endtask

    always @(negedge clk) begin
        if (stim_done) begin
            chk("timeouts", 0, tmo, 0);
            chk("leftover_expect", 0, sq.size() + dq.size(), 0);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end else if (!clr_n) begin
            for (int k = 0; k < 2; k++)
                chk("reset_outputs", k, {o_busy[k], o_done[k], o_rd[k], o_wr[k], o_err[k],
                                         o_mar[k], o_mdr[k]}, 64'd0);
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (o_rd[k] || o_wr[k]) mon_strobe(k);
                if (o_done[k]) mon_done(k);
                else if (o_err[k]) unexpected("err_outside_done", k);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mar(int k, logic [DW-1:0] v);
        for (int i = 0; i < 2; i++) if (sel(k, i)) begin d_bus[i] = v; d_mar[i] = 1'b1; end
        tick();
        for (int i = 0; i < 2; i++) d_mar[i] = 1'b0;
    endtask

    task automatic load_mdr(int k, logic [DW-1:0] v);
        for (int i = 0; i < 2; i++) if (sel(k, i)) begin d_bus[i] = v; d_mdr[i] = 1'b1; end
        tick();
        for (int i = 0; i < 2; i++) d_mdr[i] = 1'b0;
    endtask

    task automatic preload(logic [AW-1:0] a, logic [DW-1:0] v);
        pre_we = 1'b1; pre_a = a; pre_d = v;
        tick();
        pre_we = 1'b0;
    endtask

    // n is the cycle in which the request is sampled and accepted.
    task automatic push_exp(int i, int n, bit rd, logic [AW-1:0] a, logic [DW-1:0] wd,
                            logic [DW-1:0] exp_mdr, bit oob);
        if (oob) begin
            dq.push_back('{inst: i, cyc: n + 1, mar: a, mdr: exp_mdr, err: 1'b1});
        end else begin
            sq.push_back('{inst: i, cyc: n + 1, addr: a, data: wd, wr: !rd});
            dq.push_back('{inst: i, cyc: n + (rd ? 3 : 2) + ws(i), mar: a, mdr: exp_mdr, err: 1'b0});
        end
    endtask

    task automatic issue(int k, bit rd, bit wr, logic [AW-1:0] a, logic [DW-1:0] wd,
                         logic [DW-1:0] exp_mdr, bit oob);
        for (int i = 0; i < 2; i++) if (sel(k, i)) begin
            d_rd[i] = rd; d_wr[i] = wr;
            push_exp(i, cyc, rd, a, wd, exp_mdr, oob);
        end
        tick();
        for (int i = 0; i < 2; i++) begin d_rd[i] = 1'b0; d_wr[i] = 1'b0; end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sq.size() != 0 || dq.size() != 0) && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) begin
            tmo++;
            sq.delete();
            dq.delete();
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            d_bus[i] = '0; d_mar[i] = 1'b0; d_mdr[i] = 1'b0; d_rd[i] = 1'b0; d_wr[i] = 1'b0;
        end
        #1 clr_n = 1'b0;
        repeat (3) tick();
        clr_n = 1'b1;
        tick();

        // Write 69 to address 5.
        load_mar(2, 5);
        load_mdr(2, 69);
        issue(2, 0, 1, 9'd5, 69, 69, 0);
        wait_idle();

        // Read preloaded RAM[10] = 420.
        preload(9'd10, 420);
        load_mar(2, 10);
        issue(2, 1, 0, 9'd10, 0, 420, 0);
        wait_idle();

        // Read RAM[5]; MAR/MDR loads with bus=7 during busy must be ignored.
        load_mar(2, 5);
        issue(2, 1, 0, 9'd5, 0, 69, 0);
        for (int i = 0; i < 2; i++) begin d_bus[i] = 7; d_mar[i] = 1'b1; d_mdr[i] = 1'b1; end
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin d_mar[i] = 1'b0; d_mdr[i] = 1'b0; end
        wait_idle();

        // Simultaneous read and write: read wins.
        load_mar(2, 10);
        issue(2, 1, 1, 9'd10, 0, 420, 0);
        wait_idle();

        // Request held through the done cycle: ignored there, accepted the cycle after.
        for (int k = 0; k < 2; k++) begin
            issue(k, 1, 0, 9'd10, 0, 420, 0);
            repeat (2 + ws(k)) tick();
            d_rd[k] = 1'b1;
            push_exp(k, cyc + 1, 1, 9'd10, 0, 420, 0);
            tick();
            tick();
            d_rd[k] = 1'b0;
            wait_idle();
        end

        // Top address and upper-bit handling.
        load_mar(2, 32'h1FF);
        load_mdr(2, 32'hDEADBEEF);
        issue(2, 0, 1, 9'h1FF, 32'hDEADBEEF, 32'hDEADBEEF, 0);
        wait_idle();
`ifdef MEM_RANGE_CHECK_EN
        load_mdr(2, 32'h12345678);
        load_mar(2, 32'h200);
        issue(2, 1, 0, 9'h000, 0, 32'h12345678, 1);
        wait_idle();
        load_mar(2, 32'h1FF);
        issue(2, 1, 0, 9'h1FF, 0, 32'hDEADBEEF, 0);
        wait_idle();
`else
        load_mar(2, 32'h3FF);
        issue(2, 1, 0, 9'h1FF, 0, 32'hDEADBEEF, 0);
        wait_idle();
        load_mar(2, 32'h20A);
        issue(2, 1, 0, 9'h00A, 0, 420, 0);
        wait_idle();
`endif

        // Asynchronous reset in the middle of a read strobe: abort, no done.
        load_mar(2, 5);
        for (int i = 0; i < 2; i++) d_rd[i] = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) d_rd[i] = 1'b0;
        #1 clr_n = 1'b0;
        tick();
        tick();
        clr_n = 1'b1;
        repeat (6) tick();

        // MDR came out of reset as 0: a write now carries zero data.
        load_mar(2, 3);
        issue(2, 0, 1, 9'd3, 0, 0, 0);
        wait_idle();

        repeat (2) tick();
        stim_done = 1'b1;
    end
endmodule
